// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one asynchronous-read ROM between two requesters.
// Round-robin arbitration on a valid/ready request channel, one registered
// ROM access per grant, and a registered response held until the granted
// requester takes it.
//
// Optional feature macro: ROM_ARB_LOCK_EN
//   Defined   - a requester that holds req_lock at its response handshake
//               keeps the grant for as long as it keeps req_valid asserted.
//   Undefined - req_lock is ignored and arbitration is pure round-robin.
// The port list is the same in both builds.

module rom_read_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_lock,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_ce,
  output logic                  rom_read_en,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_n_s;
  logic                  grant_r;
  logic                  last_grant_r;
  logic                  lock_hold_r;
  logic                  rr_sel_s;
  logic                  grant_sel_s;
  logic                  accept_s;
  logic                  rsp_fire_s;
  logic [1:0]            req_ready_s;
  logic [1:0]            rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic [ADDR_WIDTH-1:0] rom_address_r;
  logic                  rom_ce_r;
  logic                  rom_read_en_r;

  // One-hot 2-bit vector selecting requester idx.
  function automatic logic [1:0] onehot2(input logic idx);
    onehot2 = idx ? 2'b10 : 2'b01;
  endfunction

  // Round-robin choice: a lone requester wins, a tie goes away from last_grant.
  always_comb begin
    rr_sel_s = 1'b0;
    if (req_valid == 2'b11) begin
      rr_sel_s = ~last_grant_r;
    end else if (req_valid[1]) begin
      rr_sel_s = 1'b1;
    end else begin
      rr_sel_s = 1'b0;
    end
  end

`ifdef ROM_ARB_LOCK_EN
  // Locked requester keeps the grant while it stays valid; otherwise fall back to round-robin.
  always_comb begin
    grant_sel_s = rr_sel_s;
    if (lock_hold_r && req_valid[grant_r]) begin
      grant_sel_s = grant_r;
    end else begin
      grant_sel_s = rr_sel_s;
    end
  end
`else
  // Pure round-robin grant selection.
  always_comb begin
    grant_sel_s = rr_sel_s;
  end
`endif

  // Acceptance, request ready and response handshake strobes.
  always_comb begin
    accept_s    = 1'b0;
    rsp_fire_s  = 1'b0;
    req_ready_s = 2'b00;
    if ((state_r == IDLE) && (req_valid != 2'b00)) begin
      accept_s    = 1'b1;
      req_ready_s = onehot2(grant_sel_s);
    end else begin
      accept_s    = 1'b0;
      req_ready_s = 2'b00;
    end
    if ((state_r == RESP) && rsp_ready[grant_r]) begin
      rsp_fire_s = 1'b1;
    end else begin
      rsp_fire_s = 1'b0;
    end
  end

  // Next-state logic: IDLE -> ISSUE on accept, ISSUE -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n_s = ISSUE;
        end else begin
          state_n_s = IDLE;
        end
      end
      ISSUE: begin
        state_n_s = RESP;
      end
      RESP: begin
        if (rsp_fire_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = RESP;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Grant bookkeeping: current grant latched on accept, last_grant on response handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      if (accept_s) begin
        grant_r <= grant_sel_s;
      end
      if (rsp_fire_s) begin
        last_grant_r <= grant_r;
      end
    end
  end

`ifdef ROM_ARB_LOCK_EN
  // Lock flag: captured from req_lock at the handshake, dropped when the holder goes idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_hold_r <= 1'b0;
    end else if (rsp_fire_s) begin
      lock_hold_r <= req_lock[grant_r];
    end else if ((state_r == IDLE) && lock_hold_r && !req_valid[grant_r]) begin
      lock_hold_r <= 1'b0;
    end
  end
`else
  logic [1:0] lock_unused_s;
  assign lock_unused_s = req_lock;
  assign lock_hold_r   = 1'b0;
`endif

  // ROM interface registers: address/enables loaded on accept, enables dropped after ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_address_r <= {ADDR_WIDTH{1'b0}};
      rom_ce_r      <= 1'b0;
      rom_read_en_r <= 1'b0;
    end else if (accept_s) begin
      rom_address_r <= grant_sel_s ? req_addr1 : req_addr0;
      rom_ce_r      <= 1'b1;
      rom_read_en_r <= 1'b1;
    end else if (state_r == ISSUE) begin
      rom_ce_r      <= 1'b0;
      rom_read_en_r <= 1'b0;
    end
  end

  // Response registers: capture ROM word at end of ISSUE, hold until the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (state_r == ISSUE) begin
      rsp_valid_r <= onehot2(grant_r);
      rsp_data_r  <= rom_data;
    end else if (rsp_fire_s) begin
      rsp_valid_r <= 2'b00;
    end
  end

  assign req_ready   = req_ready_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rom_address = rom_address_r;
  assign rom_ce      = rom_ce_r;
  assign rom_read_en = rom_read_en_r;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed self-checking bench for rom_read_arbiter with a 256x8 ROM model
// (mem[a] = a ^ 8'hA5). Expected lock-test grant order depends on ROM_ARB_LOCK_EN.

module tb_rom_read_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req_addr0;
  logic [7:0] req_addr1;
  logic [1:0] req_ready;
  logic [1:0] req_lock;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] rom_address;
  logic       rom_ce;
  logic       rom_read_en;
  logic [7:0] rom_data;

  int pass_cnt;
  int total_cnt;

  rom_read_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr0   (req_addr0),
    .req_addr1   (req_addr1),
    .req_ready   (req_ready),
    .req_lock    (req_lock),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rom_address (rom_address),
    .rom_ce      (rom_ce),
    .rom_read_en (rom_read_en),
    .rom_data    (rom_data)
  );

  // ROM model: asynchronous read, 0 when not enabled.
  assign rom_data = (rom_ce && rom_read_en) ? (rom_address ^ 8'hA5) : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle; sample point is 1 time unit after the falling edge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // One full 3-cycle read for requester g; inputs must already be driven.
  task automatic serve(input int g, input logic [7:0] addr, input logic [7:0] data);
    logic [1:0] oh;
    oh = (g == 1) ? 2'b10 : 2'b01;
    check($sformatf("idle_ready_g%0d", g), req_ready, oh);
    nxt();
    check("issue_ce", rom_ce, 1'b1);
    check("issue_re", rom_read_en, 1'b1);
    check("issue_addr", rom_address, addr);
    check("issue_ready", req_ready, 2'b00);
    check("issue_rsp_valid", rsp_valid, 2'b00);
    nxt();
    check($sformatf("resp_valid_g%0d", g), rsp_valid, oh);
    check("resp_data", rsp_data, data);
    check("resp_ce", rom_ce, 1'b0);
    nxt();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_addr0 = 8'h00;
    req_addr1 = 8'h00;
    req_lock  = 2'b00;
    rsp_ready = 2'b00;
    nxt();
    nxt();

    // Reset state
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rom_addr", rom_address, 8'h00);
    check("rst_rom_ce", rom_ce, 1'b0);
    check("rst_rom_re", rom_read_en, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    reset = 1'b0;
    nxt();
    check("idle_no_req_ready", req_ready, 2'b00);

    // Single read, requester 0, addr 0x10 -> 0xB5
    req_valid = 2'b01;
    req_addr0 = 8'h10;
    rsp_ready = 2'b11;
    #1;
    serve(0, 8'h10, 8'hB5);
    req_valid = 2'b00;
    #1;
    check("single_after_ready", req_ready, 2'b00);
    check("single_after_valid", rsp_valid, 2'b00);
    check("single_addr_kept", rom_address, 8'h10);
    nxt();

    // Contention after reset: requester 0 first, then strict alternation
    do_reset();
    req_valid = 2'b11;
    req_addr0 = 8'h00;
    req_addr1 = 8'hFF;
    #1;
    for (int p = 0; p < 4; p++) begin
      serve(0, 8'h00, 8'hA5);
      serve(1, 8'hFF, 8'h5A);
    end
    req_valid = 2'b00;
    nxt();

    // Response backpressure: rsp_ready[0] low for 5 RESP cycles (bit 1 is ignored)
    req_valid = 2'b01;
    req_addr0 = 8'h20;
    rsp_ready = 2'b10;
    #1;
    check("bp_idle_ready", req_ready, 2'b01);
    nxt();
    check("bp_issue_ce", rom_ce, 1'b1);
    nxt();
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", rsp_valid, 2'b01);
      check("bp_rsp_data", rsp_data, 8'h85);
      check("bp_req_ready", req_ready, 2'b00);
      check("bp_rom_ce", rom_ce, 1'b0);
      if (c < 4) begin
        nxt();
      end
    end
    rsp_ready = 2'b01;
    req_valid = 2'b00;
    nxt();
    check("bp_release_valid", rsp_valid, 2'b00);
    check("bp_release_data", rsp_data, 8'h85);
    rsp_ready = 2'b11;

    // Reset asserted during ISSUE drops the read
    req_valid = 2'b01;
    req_addr0 = 8'h33;
    #1;
    check("rmid_idle_ready", req_ready, 2'b01);
    nxt();
    req_valid = 2'b00;
    check("rmid_issue_ce", rom_ce, 1'b1);
    reset = 1'b1;
    nxt();
    check("rmid_rsp_valid", rsp_valid, 2'b00);
    check("rmid_rom_ce", rom_ce, 1'b0);
    check("rmid_rsp_data", rsp_data, 8'h00);
    check("rmid_rom_addr", rom_address, 8'h00);
    reset = 1'b0;
    nxt();
    check("rmid_no_rsp", rsp_valid, 2'b00);
    req_valid = 2'b10;
    req_addr1 = 8'h44;
    #1;
    serve(1, 8'h44, 8'hE1);
    req_valid = 2'b00;
    nxt();

    // Lock request with both requesters valid
    do_reset();
    req_valid = 2'b11;
    req_addr0 = 8'h01;
    req_addr1 = 8'h02;
    req_lock  = 2'b01;
    #1;
`ifdef ROM_ARB_LOCK_EN
    serve(0, 8'h01, 8'hA4);
    serve(0, 8'h01, 8'hA4);
    serve(0, 8'h01, 8'hA4);
`else
    serve(0, 8'h01, 8'hA4);
    serve(1, 8'h02, 8'hA7);
    serve(0, 8'h01, 8'hA4);
    serve(1, 8'h02, 8'hA7);
`endif
    req_valid = 2'b10;
    #1;
    serve(1, 8'h02, 8'hA7);
    req_valid = 2'b00;
    req_lock  = 2'b00;
    nxt();
    check("end_idle_ready", req_ready, 2'b00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
